fp_divider: RTL

FP_DIVIDER -- requirements
Module: fp_divider

---
 rtl/fp_divider_pkg.sv | 39 +++
 rtl/fp_classify.sv | 26 ++
 rtl/fp_divider.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fp_divider_pkg.sv
// Shared FP32 constants, FSM encoding and payload types for the iterative divider.
package fp_divider_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned FP_W   = 1 + EXP_W + MANT_W;
    localparam int unsigned SIG_W  = MANT_W + 1;
    localparam int unsigned SUM_W  = SIG_W + 1;
    localparam int unsigned REM_W  = SIG_W + 1;
    localparam int unsigned ITERS  = 26;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned EXPI_W = 10;
    localparam int unsigned BIAS   = 127;

    localparam logic [FP_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp32_t;

    function automatic logic [FP_W-1:0] signed_inf(input logic s);
        return {s, POS_INF[FP_W-2:0]};
    endfunction

    function automatic logic [FP_W-1:0] signed_zero(input logic s);
        return {s, {(FP_W-1){1'b0}}};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational FP32 operand classifier (sign excluded); shared with the multiplier.
module fp_classify
    import fp_divider_pkg::*;
(
    input  logic [FP_W-2:0] mag,
    output logic            zero_c,
    output logic            inf_c,
    output logic            nan_c,
    output logic            denorm_c
);

    logic exp_zero;
    logic exp_ones;
    logic mant_zero;

    always_comb begin
        exp_zero  = (mag[FP_W-2:MANT_W] == '0);
        exp_ones  = (mag[FP_W-2:MANT_W] == '1);
        mant_zero = (mag[MANT_W-1:0] == '0);
        zero_c    = exp_zero & mant_zero;
        denorm_c  = exp_zero & ~mant_zero;
        inf_c     = exp_ones & mant_zero;
        nan_c     = exp_ones & ~mant_zero;
    end

endmodule

// File: rtl/fp_divider.sv
// Iterative IEEE-754 single-precision divider: restoring mantissa division,
// one quotient bit per cycle, round-to-nearest-even, denormals flushed to zero.
module fp_divider
    import fp_divider_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] quotient,
    output logic            div_by_zero,
    output logic            invalid
);

    state_t state;

    logic              sign_q;
    logic [SIG_W-1:0]  divisor_q;
    logic [REM_W-1:0]  rem_q;
    logic [ITERS-1:0]  quo_q;
    logic [EXPI_W-1:0] exp_q;
    logic [CNT_W-1:0]  cnt_q;

    fp32_t fa;
    fp32_t fb;
    assign fa = a;
    assign fb = b;

    logic a_zero, a_inf, a_nan, a_den;
    logic b_zero, b_inf, b_nan, b_den;

    fp_classify u_class_a (
        .mag      (a[FP_W-2:0]),
        .zero_c   (a_zero),
        .inf_c    (a_inf),
        .nan_c    (a_nan),
        .denorm_c (a_den)
    );

    fp_classify u_class_b (
        .mag      (b[FP_W-2:0]),
        .zero_c   (b_zero),
        .inf_c    (b_inf),
        .nan_c    (b_nan),
        .denorm_c (b_den)
    );

    // Operand setup and special-case resolution at acceptance
    logic              sign_c;
    logic              a_z, b_z;
    logic [SIG_W-1:0]  ma_c, mb_c;
    logic              a_lt_b_c;
    logic [EXPI_W-1:0] exp_init_c;
    logic              spec_c;
    logic [FP_W-1:0]   spec_q_c;
    logic              spec_dz_c;
    logic              spec_inv_c;

    always_comb begin
        sign_c     = fa.sign ^ fb.sign;
        a_z        = a_zero | a_den;
        b_z        = b_zero | b_den;
        ma_c       = {1'b1, fa.mant};
        mb_c       = {1'b1, fb.mant};
        a_lt_b_c   = (ma_c < mb_c);
        exp_init_c = EXPI_W'(fa.exp) - EXPI_W'(fb.exp) + EXPI_W'(BIAS)
                   - EXPI_W'(a_lt_b_c);

        spec_c     = 1'b0;
        spec_q_c   = '0;
        spec_dz_c  = 1'b0;
        spec_inv_c = 1'b0;
        if (a_nan | b_nan | (a_z & b_z) | (a_inf & b_inf)) begin
            spec_c     = 1'b1;
            spec_q_c   = QNAN;
            spec_inv_c = 1'b1;
        end else if (b_z) begin
            spec_c    = 1'b1;
            spec_q_c  = signed_inf(sign_c);
            spec_dz_c = ~a_inf;
        end else if (a_inf) begin
            spec_c   = 1'b1;
            spec_q_c = signed_inf(sign_c);
        end else if (a_z | b_inf) begin
            spec_c   = 1'b1;
            spec_q_c = signed_zero(sign_c);
        end
    end

    // One restoring-division step
    logic             ge_c;
    logic [REM_W-1:0] rem_sub_c;
    logic [REM_W-1:0] rem_nxt_c;

    always_comb begin
        ge_c      = (rem_q >= REM_W'(divisor_q));
        rem_sub_c = ge_c ? (rem_q - REM_W'(divisor_q)) : rem_q;
        rem_nxt_c = rem_sub_c << 1;
    end

    // Rounding, renormalisation and range clamp of the finished quotient
    logic              guard_c;
    logic              sticky_c;
    logic              round_up_c;
    logic [SUM_W-1:0]  rnd_sum_c;
    logic [EXPI_W-1:0] exp_fin_c;
    logic [MANT_W-1:0] frac_c;
    logic [FP_W-1:0]   norm_q_c;

    always_comb begin
        guard_c    = quo_q[1];
        sticky_c   = quo_q[0] | (|rem_q);
        round_up_c = guard_c & (sticky_c | quo_q[2]);
        rnd_sum_c  = {1'b0, quo_q[ITERS-1:2]} + SUM_W'(round_up_c);
        exp_fin_c  = exp_q + EXPI_W'(rnd_sum_c[SUM_W-1]);
        frac_c     = rnd_sum_c[SUM_W-1] ? rnd_sum_c[SUM_W-2:1]
                                        : rnd_sum_c[MANT_W-1:0];
        if ($signed(exp_fin_c) >= 10'sd255) begin
            norm_q_c = signed_inf(sign_q);
        end else if ($signed(exp_fin_c) <= 10'sd0) begin
            norm_q_c = signed_zero(sign_q);
        end else begin
            norm_q_c = {sign_q, exp_fin_c[EXP_W-1:0], frac_c};
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            sign_q      <= 1'b0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            exp_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (spec_c) begin
                            quotient    <= spec_q_c;
                            div_by_zero <= spec_dz_c;
                            invalid     <= spec_inv_c;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            sign_q    <= sign_c;
                            divisor_q <= mb_c;
                            rem_q     <= a_lt_b_c ? {ma_c, 1'b0} : {1'b0, ma_c};
                            quo_q     <= '0;
                            exp_q     <= exp_init_c;
                            cnt_q     <= '0;
                            state     <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_q <= rem_nxt_c;
                    quo_q <= {quo_q[ITERS-2:0], ge_c};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERS - 1)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    quotient    <= norm_q_c;
                    div_by_zero <= 1'b0;
                    invalid     <= 1'b0;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
